// File: rtl/tdc_meas_ctrl.sv
// tdc_meas_ctrl
// Measurement sequencer for the TDC. It fires a programmed burst of launch
// strobes, one at a time. After each launch it waits for the TDC hit weight
// or for a timeout. It accumulates sum, min, max, the valid-sample count and
// the timeout count, then offers the burst summary on a valid/ready port.
//
// Ports:
//   clk, rst             clock (clk_capture domain), sync active-high reset
//   en                   global enable; low freezes all state
//   start, n_samples     begin a burst of n_samples launches (IDLE only)
//   busy                 high whenever the sequencer is not IDLE
//   tdc_val_in           launch strobe to the TDC, one cycle per sample
//   tdc_hw, tdc_val_out  TDC result stream
//   res_*                burst summary; res_valid/res_ready handshake
module tdc_meas_ctrl #(
  parameter  int N       = 64,
  parameter  int CNT_W   = 8,
  parameter  int TIMEOUT = 255,
  localparam int HW_W    = $clog2(N) + 1,
  localparam int SUM_W   = HW_W + CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic [CNT_W-1:0] n_samples,
  output logic             busy,
  output logic             tdc_val_in,
  input  logic [HW_W-1:0]  tdc_hw,
  input  logic             tdc_val_out,
  output logic [SUM_W-1:0] res_sum,
  output logic [HW_W-1:0]  res_min,
  output logic [HW_W-1:0]  res_max,
  output logic [CNT_W-1:0] res_cnt,
  output logic [CNT_W-1:0] res_timeouts,
  output logic             res_valid,
  input  logic             res_ready
);

  localparam int TMR_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_t;

  state_t           state;
  logic             launch_q;
  logic [CNT_W-1:0] n_lat;
  logic [CNT_W-1:0] issued;
  logic [CNT_W-1:0] issued_nxt;
  logic [TMR_W-1:0] timer;
  logic             last;

  assign issued_nxt = issued + 1'b1;
  assign last       = (issued_nxt == n_lat);

  // launch_q is the registered LAUNCH flag. It is gated with en so that the
  // strobe drops as soon as the block is frozen. The state stays in LAUNCH
  // while frozen, so the pulse is delivered once en returns.
  assign tdc_val_in = launch_q & en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      launch_q     <= 1'b0;
      busy         <= 1'b0;
      res_valid    <= 1'b0;
      res_sum      <= '0;
      res_cnt      <= '0;
      res_timeouts <= '0;
      res_max      <= '0;
      res_min      <= HW_W'(N);
      n_lat        <= '0;
      issued       <= '0;
      timer        <= '0;
    end else if (en) begin
      case (state)
        IDLE: begin
          if (start) begin
            n_lat        <= n_samples;
            issued       <= '0;
            res_sum      <= '0;
            res_cnt      <= '0;
            res_timeouts <= '0;
            res_max      <= '0;
            res_min      <= HW_W'(N);
            busy         <= 1'b1;
            // An empty burst goes straight to DONE with the cleared summary.
            if (n_samples != '0) begin
              state    <= LAUNCH;
              launch_q <= 1'b1;
            end else begin
              state     <= DONE;
              res_valid <= 1'b1;
            end
          end
        end

        LAUNCH: begin
          launch_q <= 1'b0;
          timer    <= TMR_W'(TIMEOUT);
          state    <= WAIT;
        end

        WAIT: begin
          // A result beats the timeout, even on the timer==0 cycle.
          if (tdc_val_out || timer == '0) begin
            if (tdc_val_out) begin
              res_sum <= res_sum + SUM_W'(tdc_hw);
              res_cnt <= res_cnt + 1'b1;
              if (tdc_hw < res_min) res_min <= tdc_hw;
              if (tdc_hw > res_max) res_max <= tdc_hw;
            end else begin
              res_timeouts <= res_timeouts + 1'b1;
            end
            issued <= issued_nxt;
            if (last) begin
              state     <= DONE;
              res_valid <= 1'b1;
            end else begin
              state    <= LAUNCH;
              launch_q <= 1'b1;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end

        DONE: begin
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Self-checking bench for tdc_meas_ctrl. A table of directed bursts and a set
// of randomized bursts are applied. The bench plays the TDC: each planned
// sample is answered after a given delay, or left unanswered so that it times
// out. The expected summary comes from the burst plan. Hand-written sequences
// cover enable freezing, mid-burst reset and the empty burst.
module tb_tdc_meas_ctrl;
  localparam int N     = 64;
  localparam int CNT_W = 8;
  localparam int T     = 8;
  localparam int HW_W  = 7;
  localparam int SUM_W = 15;

  logic             clk = 1'b0;
  logic             rst, en, start, res_ready, tdc_val_out;
  logic [CNT_W-1:0] n_samples;
  logic [HW_W-1:0]  tdc_hw;
  logic             busy, tdc_val_in, res_valid;
  logic [SUM_W-1:0] res_sum;
  logic [HW_W-1:0]  res_min, res_max;
  logic [CNT_W-1:0] res_cnt, res_timeouts;

  int vectors = 0;
  int miscompares = 0;

  // burst plan consumed by run_burst
  int p_hw[8];
  bit p_resp[8];
  int p_dly[8];

  typedef struct {
    int n;
    int hw[4];
    bit resp[4];
    int dly[4];
    int rdy;
    int e_sum, e_min, e_max, e_cnt, e_to;
  } vec_t;

  vec_t tbl[5];

  tdc_meas_ctrl #(.N(N), .CNT_W(CNT_W), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .n_samples(n_samples),
    .busy(busy), .tdc_val_in(tdc_val_in), .tdc_hw(tdc_hw),
    .tdc_val_out(tdc_val_out), .res_sum(res_sum), .res_min(res_min),
    .res_max(res_max), .res_cnt(res_cnt), .res_timeouts(res_timeouts),
    .res_valid(res_valid), .res_ready(res_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete, got no summary, expected one");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_res(input string tag, input int s, input int mn,
                         input int mx, input int c, input int to);
    chk({tag, "_sum"}, res_sum, s);
    chk({tag, "_min"}, res_min, mn);
    chk({tag, "_max"}, res_max, mx);
    chk({tag, "_cnt"}, res_cnt, c);
    chk({tag, "_timeouts"}, res_timeouts, to);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_val_in"}, tdc_val_in, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk_res(tag, 0, N, 0, 0, 0);
  endtask

  // Run one burst from IDLE using p_* as the TDC behaviour, then hold the
  // summary for rdy_wait cycles (with stray start/val_out) and accept it.
  task automatic run_burst(input string tag, input int n, input int rdy_wait,
                           input int e_sum, input int e_min, input int e_max,
                           input int e_cnt, input int e_to);
    start = 1'b1;
    n_samples = CNT_W'(n);
    tick();
    start = 1'b0;
    n_samples = CNT_W'($urandom);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_launch"}, tdc_val_in, 1);
      chk({tag, "_busy"}, busy, 1);
      // a result seen while launching is stale and must be dropped
      tdc_val_out = 1'($urandom_range(0, 1));
      tdc_hw = HW_W'($urandom);
      for (int j = 1; j <= T + 1; j++) begin
        tick();
        tdc_val_out = 1'b0;
        chk({tag, "_wait_no_launch"}, tdc_val_in, 0);
        if (p_resp[i] && j == p_dly[i]) begin
          tdc_val_out = 1'b1;
          tdc_hw = HW_W'(p_hw[i]);
          break;
        end
      end
      tick();
      tdc_val_out = 1'b0;
    end
    chk({tag, "_done_valid"}, res_valid, 1);
    chk({tag, "_done_busy"}, busy, 1);
    chk({tag, "_done_val_in"}, tdc_val_in, 0);
    chk_res(tag, e_sum, e_min, e_max, e_cnt, e_to);
    for (int w = 0; w < rdy_wait; w++) begin
      start = (w % 2 == 0);
      n_samples = 8'd3;
      tdc_val_out = 1'b1;
      tdc_hw = HW_W'($urandom);
      tick();
      chk({tag, "_hold_valid"}, res_valid, 1);
      chk({tag, "_hold_busy"}, busy, 1);
      chk({tag, "_hold_val_in"}, tdc_val_in, 0);
      chk_res({tag, "_hold"}, e_sum, e_min, e_max, e_cnt, e_to);
    end
    start = 1'b0;
    tdc_val_out = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk({tag, "_idle_valid"}, res_valid, 0);
    chk({tag, "_idle_busy"}, busy, 0);
    chk_res({tag, "_idle"}, e_sum, e_min, e_max, e_cnt, e_to);
    tick();
    chk({tag, "_idle_val_in"}, tdc_val_in, 0);
  endtask

  initial begin
    int n, e_sum, e_min, e_max, e_cnt, e_to;

    tbl[0].n = 4; tbl[0].hw = '{10, 20, 30, 40}; tbl[0].resp = '{1, 1, 1, 1};
    tbl[0].dly = '{3, 3, 3, 3}; tbl[0].rdy = 5;
    tbl[0].e_sum = 100; tbl[0].e_min = 10; tbl[0].e_max = 40; tbl[0].e_cnt = 4; tbl[0].e_to = 0;
    tbl[1].n = 2; tbl[1].hw = '{0, 0, 0, 0}; tbl[1].resp = '{0, 0, 0, 0};
    tbl[1].dly = '{1, 1, 1, 1}; tbl[1].rdy = 0;
    tbl[1].e_sum = 0; tbl[1].e_min = 64; tbl[1].e_max = 0; tbl[1].e_cnt = 0; tbl[1].e_to = 2;
    tbl[2].n = 1; tbl[2].hw = '{5, 0, 0, 0}; tbl[2].resp = '{1, 0, 0, 0};
    tbl[2].dly = '{T + 1, 1, 1, 1}; tbl[2].rdy = 2;
    tbl[2].e_sum = 5; tbl[2].e_min = 5; tbl[2].e_max = 5; tbl[2].e_cnt = 1; tbl[2].e_to = 0;
    tbl[3].n = 3; tbl[3].hw = '{100, 0, 64, 0}; tbl[3].resp = '{1, 0, 1, 0};
    tbl[3].dly = '{1, 1, 5, 1}; tbl[3].rdy = 1;
    tbl[3].e_sum = 164; tbl[3].e_min = 64; tbl[3].e_max = 100; tbl[3].e_cnt = 2; tbl[3].e_to = 1;
    tbl[4].n = 2; tbl[4].hw = '{0, 127, 0, 0}; tbl[4].resp = '{1, 1, 0, 0};
    tbl[4].dly = '{1, 2, 1, 1}; tbl[4].rdy = 0;
    tbl[4].e_sum = 127; tbl[4].e_min = 0; tbl[4].e_max = 127; tbl[4].e_cnt = 2; tbl[4].e_to = 0;

    rst = 1'b1; en = 1'b1; start = 1'b0; n_samples = '0;
    tdc_hw = '0; tdc_val_out = 1'b0; res_ready = 1'b0;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;
    chk_reset("reset");

    // directed table
    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < 4; i++) begin
        p_hw[i] = tbl[t].hw[i];
        p_resp[i] = tbl[t].resp[i];
        p_dly[i] = tbl[t].dly[i];
      end
      run_burst($sformatf("tbl%0d", t), tbl[t].n, tbl[t].rdy, tbl[t].e_sum,
                tbl[t].e_min, tbl[t].e_max, tbl[t].e_cnt, tbl[t].e_to);
    end

    // enable frozen during LAUNCH, then mid-WAIT at timer=4
    start = 1'b1; n_samples = 8'd1;
    tick();
    start = 1'b0;
    chk("en_launch_on", tdc_val_in, 1);
    en = 1'b0;
    #1;
    chk("en_launch_gated", tdc_val_in, 0);
    repeat (3) begin
      tick();
      chk("en_launch_hold_val_in", tdc_val_in, 0);
      chk("en_launch_hold_busy", busy, 1);
    end
    en = 1'b1;
    #1;
    chk("en_launch_resume", tdc_val_in, 1);
    repeat (5) begin
      tick();
      chk("en_wait_val_in", tdc_val_in, 0);
    end
    en = 1'b0; tdc_val_out = 1'b1; tdc_hw = 7'd7;
    repeat (10) begin
      tick();
      chk("en_frozen_val_in", tdc_val_in, 0);
      chk("en_frozen_busy", busy, 1);
      chk("en_frozen_valid", res_valid, 0);
    end
    tdc_val_out = 1'b0; en = 1'b1;
    repeat (4) begin
      tick();
      chk("en_not_early_valid", res_valid, 0);
      chk("en_not_early_busy", busy, 1);
    end
    tick();
    chk("en_timeout_valid", res_valid, 1);
    chk_res("en_timeout", 0, 64, 0, 0, 1);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("en_idle_valid", res_valid, 0);
    chk("en_idle_busy", busy, 0);

    // reset in the middle of the second WAIT; late result afterwards
    start = 1'b1; n_samples = 8'd3;
    tick();
    start = 1'b0;
    tick();
    tdc_val_out = 1'b1; tdc_hw = 7'd20;
    tick();
    tdc_val_out = 1'b0;
    chk("rst_pre_sum", res_sum, 20);
    chk("rst_pre_launch", tdc_val_in, 1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; tdc_val_out = 1'b1; tdc_hw = 7'd33;
    chk_reset("rst_mid");
    repeat (3) begin
      tick();
      chk_reset("rst_after");
    end
    tdc_val_out = 1'b0;

    // empty burst
    run_burst("zero", 0, 1, 0, 64, 0, 0, 0);

    // randomized bursts against the plan-derived summary
    for (int b = 0; b < 40; b++) begin
      n = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
      e_sum = 0; e_min = N; e_max = 0; e_cnt = 0; e_to = 0;
      for (int i = 0; i < 8; i++) begin
        p_resp[i] = ($urandom_range(0, 3) != 0);
        p_hw[i] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(65, 127))
                                              : int'($urandom_range(0, 64));
        p_dly[i] = int'($urandom_range(1, T + 1));
      end
      for (int i = 0; i < n; i++) begin
        if (p_resp[i]) begin
          e_sum += p_hw[i];
          e_cnt++;
          if (p_hw[i] < e_min) e_min = p_hw[i];
          if (p_hw[i] > e_max) e_max = p_hw[i];
        end else begin
          e_to++;
        end
      end
      run_burst($sformatf("rand%0d", b), n, int'($urandom_range(0, 3)),
                e_sum, e_min, e_max, e_cnt, e_to);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/tdc_meas_ctrl.md
Name: tdc_meas_ctrl

Overview:
- Measurement sequencer that drives the TDC launch strobe and consumes the TDC result stream (hit-weight `hw` plus its valid).
- Issues a programmed burst of launches, one at a time. Waits for each result with a timeout, then accumulates sum, min, max, valid-sample count and timeout count.
- Presents the burst summary on a valid/ready result port.
- Sits in the clk_capture domain beside the TDC pop-count output.

Parameters:
- N, 64, TDC delay-line length; hit-weight width HW_W = $clog2(N)+1.
- CNT_W, 8, width of burst-length and counter fields.
- TIMEOUT, 255, wait cycles per launch before a sample is declared lost; must be ≥1.
- SUM_W derived, HW_W+CNT_W; not overridable.

Ports:
- clk  in  1  single clock (connected to clk_capture).
- rst  in  1  synchronous, active-high reset.
- en  in  1  global enable; low freezes all state.
- start  in  1  begin burst; sampled only in IDLE with en=1.
- n_samples  in  CNT_W  launches per burst; latched at start.
- busy  out  1  high in any state other than IDLE.
- tdc_val_in  out  1  launch strobe to the TDC, one cycle per sample.
- tdc_hw  in  HW_W  TDC hit weight, valid with tdc_val_out.
- tdc_val_out  in  1  TDC result valid.
- res_sum  out  SUM_W  sum of valid hw samples.
- res_min  out  HW_W  minimum valid hw.
- res_max  out  HW_W  maximum valid hw.
- res_cnt  out  CNT_W  number of valid samples.
- res_timeouts  out  CNT_W  number of timed-out launches.
- res_valid  out  1  summary valid.
- res_ready  in  1  consumer accepts summary.

Behaviour:
- Reset values: state IDLE; busy=0; tdc_val_in=0; res_valid=0; res_sum=0; res_cnt=0; res_timeouts=0; res_max=0; res_min=N; internal issued count=0; timer=0.
- en=0:
  - state, timer and all registers hold;
  - tdc_val_in forced 0;
  - tdc_val_out ignored.
  - rst overrides en.
- FSM states:
  - IDLE:
    - start=1: latch n_samples, clear accumulators (res_min=N), issued=0.
    - n_samples≠0 → LAUNCH.
    - n_samples=0 → DONE with cleared accumulators.
  - LAUNCH (one cycle): tdc_val_in=1 (registered, high exactly while in LAUNCH); timer←TIMEOUT; → WAIT.
  - WAIT:
    - tdc_val_out=1 takes priority, including when timer=0:
      - res_sum += tdc_hw;
      - res_cnt++;
      - res_min = min(res_min, tdc_hw);
      - res_max = max(res_max, tdc_hw);
      - issued++.
    - Else if timer=0: res_timeouts++, issued++.
    - Else timer--.
    - After a sample or timeout: if issued+1 = latched n → DONE, else → LAUNCH.
    - WAIT lasts at most TIMEOUT+1 cycles.
  - DONE:
    - res_valid=1 and all res_* held stable.
    - res_ready=1 → IDLE next cycle; res_valid=0 from then.
    - res_* keep their values in IDLE until the next start.
- start outside IDLE is ignored.
- tdc_val_out outside WAIT is ignored (stale or late results discarded).
- tdc_hw values >N are not clamped; they are accumulated as-is.
- Latency:
  - start sampled at edge k → tdc_val_in high in cycle k+1.
  - A result in WAIT at edge m → next tdc_val_in in cycle m+1; accumulators updated and visible in cycle m+1.
  - Final sample at edge m → res_valid high in cycle m+1.
- Arithmetic:
  - res_sum cannot overflow (SUM_W sized for 2^CNT_W−1 samples of value ≤N).
  - Counters do not wrap because the burst length is ≤2^CNT_W−1.
- Reset mid-burst: immediate return to reset values; no further launches.

Test Plan:
1. n_samples=4; TDC returns hw=10,20,30,40, each 3 cycles after tdc_val_in → exactly 4 single-cycle launch pulses; res_sum=100, res_min=10, res_max=40, res_cnt=4, res_timeouts=0, res_valid=1.
2. TIMEOUT=8, n_samples=2, no tdc_val_out → each WAIT lasts 9 cycles; res_cnt=0, res_timeouts=2, res_sum=0, res_min=64, res_max=0.
3. TIMEOUT=8, n_samples=1, tdc_val_out with hw=5 on the cycle timer=0 → counted as valid: res_cnt=1, res_timeouts=0, res_sum=5; a second val_out in DONE leaves res_sum=5.
4. Burst completes, res_ready held low 5 cycles, start pulsed → res_* stable, no launches, busy=1; res_ready=1 → next cycle IDLE, res_valid=0, busy=0.
5. en dropped for 10 cycles mid-WAIT (TIMEOUT=8, timer=4) → timer holds at 4 and tdc_val_in stays 0; after en=1, timeout fires 4 cycles later, not earlier.
6. rst asserted mid-WAIT; TDC result arrives afterwards → all outputs at reset values, res_min=64, result ignored. Separately, start with n_samples=0 → DONE next cycle with res_cnt=0, res_sum=0, and no tdc_val_in pulse.
